// File: rtl/i2c_bus_watchdog.sv
// i2c_bus_watchdog
//   Watches the I2C bus for SCL or SDA stuck low. While the bus is low the
//   external millisecond timeout counter is enabled and fed a 1 ms tick. If
//   that counter times out, SCL is clocked until the slave lets SDA go (up to
//   RECOV_PULSES times), a STOP is generated, and the bus is checked again.
//
// Ports
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   wd_enable          : enables entry into monitoring
//   scl_in, sda_in     : raw pad levels (asynchronous)
//   clr_stuck          : leaves FAULT and clears stuck_flag
//   timeout            : from the external timeout counter
//   cnt_en, cnt_size, cnt_pulse : control of the external timeout counter
//   scl_oe, sda_oe     : open-drain pull-low enables (1 = drive low)
//   recov_busy         : recovery or STOP in progress
//   recov_done         : one-cycle pulse after a successful recovery
//   stuck_flag         : sticky, recovery failed
//   recov_cnt          : successful recoveries, saturating at 255
module i2c_bus_watchdog #(
  parameter int CLK_PER_MS   = 33000,
  parameter int TIMEOUT_MS   = 25,
  parameter int HALF_CLKS    = 165,
  parameter int RECOV_PULSES = 9
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        wd_enable,
  input  logic        scl_in,
  input  logic        sda_in,
  input  logic        clr_stuck,
  input  logic        timeout,
  output logic        cnt_en,
  output logic [10:0] cnt_size,
  output logic        cnt_pulse,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        recov_busy,
  output logic        recov_done,
  output logic        stuck_flag,
  output logic [7:0]  recov_cnt
);

  localparam logic [15:0] C_PRESC_LAST = 16'(CLK_PER_MS - 1);
  localparam logic [11:0] C_HALF_LAST  = 12'(HALF_CLKS - 1);
  localparam logic [3:0]  C_PULSES     = 4'(RECOV_PULSES);

  typedef enum logic [2:0] {
    S_IDLE, S_MON, S_RC_LO, S_RC_HI, S_ST_A, S_ST_B, S_ST_C, S_FAULT
  } state_t;

  state_t      r_state;
  logic        r_scl_meta, r_scl_s, r_sda_meta, r_sda_s;
  logic [15:0] r_presc;
  logic [11:0] r_half;
  logic [3:0]  r_pulse_cnt;
  logic        r_cnt_en, r_cnt_pulse, r_scl_oe, r_sda_oe;
  logic        r_recov_busy, r_recov_done, r_stuck_flag;
  logic [7:0]  r_recov_cnt;

  logic        w_bus_low;
  logic        w_half_last;
  logic [3:0]  w_pulse_nxt;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_bus_low   = ~r_scl_s | ~r_sda_s;
  assign w_half_last = (r_half == C_HALF_LAST);
  assign w_pulse_nxt = r_pulse_cnt + 4'd1;

  // Synchronizer stage: pads idle high, so reset to 1 to avoid a false low.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_scl_meta <= 1'b1;
      r_scl_s    <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_s    <= 1'b1;
    end else begin
      r_scl_meta <= scl_in;
      r_scl_s    <= r_scl_meta;
      r_sda_meta <= sda_in;
      r_sda_s    <= r_sda_meta;
    end
  end

  // Prescaler stage: value k during the k-th cycle of MON (mod CLK_PER_MS).
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_presc <= 16'd0;
    end else if (!r_cnt_en || r_presc == C_PRESC_LAST) begin
      r_presc <= 16'd0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  // Control FSM stage: all outputs are registered alongside the state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state      <= S_IDLE;
      r_half       <= 12'd0;
      r_pulse_cnt  <= 4'd0;
      r_cnt_en     <= 1'b0;
      r_cnt_pulse  <= 1'b0;
      r_scl_oe     <= 1'b0;
      r_sda_oe     <= 1'b0;
      r_recov_busy <= 1'b0;
      r_recov_done <= 1'b0;
      r_stuck_flag <= 1'b0;
      r_recov_cnt  <= 8'd0;
    end else begin
      r_cnt_pulse  <= 1'b0;
      r_recov_done <= 1'b0;
      r_half       <= r_half + 12'd1;
      case (r_state)
        S_IDLE: begin
          if (wd_enable && w_bus_low) begin
            r_state  <= S_MON;
            r_cnt_en <= 1'b1;
            r_half   <= 12'd0;
          end
        end
        S_MON: begin
          // Timeout wins over a release seen in the same cycle.
          if (timeout) begin
            r_state      <= S_RC_LO;
            r_cnt_en     <= 1'b0;
            r_scl_oe     <= 1'b1;
            r_recov_busy <= 1'b1;
            r_pulse_cnt  <= 4'd0;
            r_half       <= 12'd0;
          end else if (!w_bus_low || !wd_enable) begin
            r_state  <= S_IDLE;
            r_cnt_en <= 1'b0;
            r_half   <= 12'd0;
          end else begin
            // Tick lands on the cycle after the prescaler wraps, so the
            // first one is CLK_PER_MS cycles after cnt_en rises.
            r_cnt_pulse <= (r_presc == C_PRESC_LAST);
          end
        end
        S_RC_LO: begin
          if (w_half_last) begin
            r_state  <= S_RC_HI;
            r_scl_oe <= 1'b0;
            r_half   <= 12'd0;
          end
        end
        S_RC_HI: begin
          if (w_half_last) begin
            r_pulse_cnt <= w_pulse_nxt;
            r_half      <= 12'd0;
            r_scl_oe    <= 1'b1;
            if (r_sda_s || w_pulse_nxt == C_PULSES) begin
              r_state  <= S_ST_A;
              r_sda_oe <= 1'b1;
            end else begin
              r_state <= S_RC_LO;
            end
          end
        end
        S_ST_A: begin
          if (w_half_last) begin
            r_state  <= S_ST_B;
            r_scl_oe <= 1'b0;
            r_half   <= 12'd0;
          end
        end
        S_ST_B: begin
          // SDA rising while SCL is high forms the STOP condition.
          if (w_half_last) begin
            r_state  <= S_ST_C;
            r_sda_oe <= 1'b0;
            r_half   <= 12'd0;
          end
        end
        S_ST_C: begin
          if (w_half_last) begin
            r_recov_busy <= 1'b0;
            r_half       <= 12'd0;
            if (r_scl_s && r_sda_s) begin
              r_state      <= S_IDLE;
              r_recov_done <= 1'b1;
              r_recov_cnt  <= sat_inc8(r_recov_cnt);
            end else begin
              r_state      <= S_FAULT;
              r_stuck_flag <= 1'b1;
            end
          end
        end
        S_FAULT: begin
          if (clr_stuck) begin
            r_state      <= S_IDLE;
            r_stuck_flag <= 1'b0;
            r_half       <= 12'd0;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt_en     <= 1'b0;
          r_scl_oe     <= 1'b0;
          r_sda_oe     <= 1'b0;
          r_recov_busy <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_en     = r_cnt_en;
  assign cnt_size   = 11'(TIMEOUT_MS);
  assign cnt_pulse  = r_cnt_pulse;
  assign scl_oe     = r_scl_oe;
  assign sda_oe     = r_sda_oe;
  assign recov_busy = r_recov_busy;
  assign recov_done = r_recov_done;
  assign stuck_flag = r_stuck_flag;
  assign recov_cnt  = r_recov_cnt;

endmodule

// File: tb/tb_i2c_bus_watchdog.sv
// Testbench for i2c_bus_watchdog: models the open-drain bus, a slave that
// holds SDA low for a chosen number of SCL rising edges, and the external
// millisecond timeout counter. Recovery outcomes are predicted from the
// rule "pulses = min(release edge, RECOV_PULSES); success if SDA is free
// by the end of the STOP".
module tb_i2c_bus_watchdog;

  localparam int CPM = 10;
  localparam int TMS = 3;
  localparam int HC  = 4;
  localparam int RP  = 9;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        wd_enable = 1'b0;
  logic        clr_stuck = 1'b0;
  logic        scl_drv = 1'b1;
  logic        slave_hold = 1'b0;
  int          slave_n = 0;
  int          slave_base = 0;
  int          scl_rises = 0;
  int          tcnt = 0;
  int          mon_oe_cycles = 0;
  int          mon_pulse_off = 0;

  logic        scl_bus, sda_bus, timeout;
  logic        cnt_en, cnt_pulse, scl_oe, sda_oe;
  logic        recov_busy, recov_done, stuck_flag;
  logic [10:0] cnt_size;
  logic [7:0]  recov_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pulses, m_lo, m_hi, m_sta, m_stb, m_busy, m_done;
  int m_lat_en, m_en_to, m_to_busy, m_done_end, m_done_after;

  i2c_bus_watchdog #(
    .CLK_PER_MS(CPM), .TIMEOUT_MS(TMS), .HALF_CLKS(HC), .RECOV_PULSES(RP)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .wd_enable(wd_enable),
    .scl_in(scl_bus), .sda_in(sda_bus), .clr_stuck(clr_stuck),
    .timeout(timeout), .cnt_en(cnt_en), .cnt_size(cnt_size),
    .cnt_pulse(cnt_pulse), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .recov_busy(recov_busy), .recov_done(recov_done),
    .stuck_flag(stuck_flag), .recov_cnt(recov_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  // Open-drain bus with the slave holding SDA until its n-th SCL rise.
  assign scl_bus = scl_drv & ~scl_oe;
  assign sda_bus = ~sda_oe & ~(slave_hold && (scl_rises - slave_base) < slave_n);

  always @(posedge scl_bus) scl_rises <= scl_rises + 1;

  // External timeout counter: counts ticks while enabled, flags the TMS-th.
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     tcnt <= 0;
    else if (!cnt_en)   tcnt <= 0;
    else if (cnt_pulse) tcnt <= tcnt + 1;
  end
  assign timeout = cnt_en && ((tcnt + (cnt_pulse ? 1 : 0)) >= TMS);

  always @(negedge sys_clk) begin
    if (scl_oe || sda_oe)     mon_oe_cycles <= mon_oe_cycles + 1;
    if (cnt_pulse && !cnt_en) mon_pulse_off <= mon_pulse_off + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed hang, required finish");
    $fatal(1, "bench time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_en(input logic lvl, input int budget, output int n);
    n = 0;
    while (cnt_en !== lvl && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_pulse(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (cnt_pulse !== 1'b1 && n < budget);
  endtask

  task automatic run_recovery(input int n_rel, input bit drop_wd, input bit clr_mid);
    int  n;
    logic prev_scl;
    slave_base = scl_rises;
    slave_n    = n_rel;
    slave_hold = 1'b1;
    m_pulses = 0; m_lo = 0; m_hi = 0; m_sta = 0; m_stb = 0; m_busy = 0; m_done = 0;
    wait_en(1'b1, 20, m_lat_en);
    n = 0;
    while (timeout !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    m_en_to = n;
    n = 0;
    do begin
      tick();
      n++;
    end while (recov_busy !== 1'b1 && n < 10);
    m_to_busy = n;
    prev_scl = 1'b0;
    n = 0;
    while (recov_busy === 1'b1 && n < 500) begin
      if (n == 0 && drop_wd) wd_enable = 1'b0;
      clr_stuck = clr_mid && (n == 5);
      m_busy++;
      if (scl_oe && !sda_oe)              m_lo++;
      if (scl_oe && !prev_scl && !sda_oe) m_pulses++;
      if (!scl_oe && !sda_oe)             m_hi++;
      if (scl_oe && sda_oe)               m_sta++;
      if (!scl_oe && sda_oe)              m_stb++;
      if (recov_done)                     m_done++;
      prev_scl = scl_oe;
      tick();
      n++;
    end
    clr_stuck = 1'b0;
    m_done_end = recov_done ? 1 : 0;
    tick();
    m_done_after = recov_done ? 1 : 0;
  endtask

  initial begin
    int n, np, nrel, exp_cnt, oe_snap, off_snap, len;
    bit ok;
    int rel[5];
    exp_cnt = 0;

    repeat (3) tick();
    check("rst_cnt_en", 32'(cnt_en), 0);
    check("rst_cnt_pulse", 32'(cnt_pulse), 0);
    check("rst_scl_oe", 32'(scl_oe), 0);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_busy", 32'(recov_busy), 0);
    check("rst_done", 32'(recov_done), 0);
    check("rst_stuck", 32'(stuck_flag), 0);
    check("rst_recov_cnt", 32'(recov_cnt), 0);
    check("cnt_size", 32'(cnt_size), TMS);
    sys_rst_n = 1'b1;
    wd_enable = 1'b1;
    repeat (3) tick();

    // Free-running tick while SCL is held low, then an early release.
    off_snap = mon_pulse_off;
    oe_snap  = mon_oe_cycles;
    scl_drv = 1'b0;
    wait_en(1'b1, 20, n);
    check("lat_en_rise", n, 3);
    wait_pulse(20, n);
    check("tick_first", n, CPM);
    wait_pulse(20, n);
    check("tick_second", n, CPM);
    repeat ($urandom_range(0, 4)) tick();
    scl_drv = 1'b1;
    wait_en(1'b0, 20, n);
    check("lat_en_fall", n, 3);
    repeat (25) tick();
    check("no_tick_en_low", mon_pulse_off - off_snap, 0);
    check("short_no_oe", mon_oe_cycles - oe_snap, 0);

    // Random short lows below the timeout threshold.
    for (int k = 0; k < 3; k++) begin
      len = $urandom_range(5, 25);
      oe_snap = mon_oe_cycles;
      if (k == 1) scl_drv = 1'b0;
      else        begin slave_n = 1000; slave_base = scl_rises; slave_hold = 1'b1; end
      repeat (len) tick();
      scl_drv = 1'b1;
      slave_hold = 1'b0;
      wait_en(1'b0, 40, n);
      check("short_fall_lat", n, 3);
      repeat (5) tick();
      check("short_rand_no_oe", mon_oe_cycles - oe_snap, 0);
    end

    // Recovery runs: release edge chosen per run, outcome predicted.
    rel[0] = 3;
    rel[1] = RP;
    rel[2] = RP + 1;
    rel[3] = RP + 4;
    rel[4] = $urandom_range(1, RP + 3);
    for (int k = 0; k < 5; k++) begin
      nrel = rel[k];
      np = (nrel < RP) ? nrel : RP;
      ok = (nrel <= RP + 1);
      run_recovery(nrel, 1'b0, !ok);
      check("rc_lat_en", m_lat_en, 3);
      check("rc_en_to_timeout", m_en_to, TMS * CPM);
      check("rc_timeout_to_busy", m_to_busy, 1);
      check("rc_pulses", m_pulses, np);
      check("rc_scl_low", m_lo, np * HC);
      check("rc_released", m_hi, np * HC + HC);
      check("rc_stop_a", m_sta, HC);
      check("rc_stop_b", m_stb, HC);
      check("rc_busy_len", m_busy, 2 * np * HC + 3 * HC);
      check("rc_done_in_busy", m_done, 0);
      check("rc_done_pulse", m_done_end, ok ? 1 : 0);
      check("rc_done_one_cycle", m_done_after, 0);
      if (ok) exp_cnt++;
      check("rc_recov_cnt", 32'(recov_cnt), exp_cnt);
      check("rc_stuck", 32'(stuck_flag), ok ? 0 : 1);
      if (!ok) begin
        oe_snap = mon_oe_cycles;
        repeat (30) tick();
        check("fault_no_mon", 32'(cnt_en), 0);
        check("fault_no_oe", mon_oe_cycles - oe_snap, 0);
        check("fault_stuck_held", 32'(stuck_flag), 1);
        clr_stuck = 1'b1;
        tick();
        clr_stuck = 1'b0;
        check("clr_stuck", 32'(stuck_flag), 0);
        tick();
        check("reenter_mon", 32'(cnt_en), 1);
      end
      slave_hold = 1'b0;
      wait_en(1'b0, 20, n);
      check("rc_back_idle", 32'(cnt_en), 0);
      repeat (3) tick();
    end

    // wd_enable dropped while monitoring.
    scl_drv = 1'b0;
    wait_en(1'b1, 20, n);
    repeat ($urandom_range(1, 20)) tick();
    wd_enable = 1'b0;
    tick();
    check("wd_drop_en", 32'(cnt_en), 0);
    oe_snap = mon_oe_cycles;
    repeat (40) tick();
    check("wd_drop_no_oe", mon_oe_cycles - oe_snap, 0);
    check("wd_drop_stay_idle", 32'(cnt_en), 0);
    scl_drv = 1'b1;
    repeat (4) tick();
    wd_enable = 1'b1;

    // wd_enable dropped in the first recovery low phase.
    run_recovery(2, 1'b1, 1'b0);
    check("wd_rc_pulses", m_pulses, 2);
    check("wd_rc_busy_len", m_busy, 4 * HC + 3 * HC);
    check("wd_rc_done", m_done_end, 1);
    exp_cnt++;
    check("wd_rc_recov_cnt", 32'(recov_cnt), exp_cnt);
    slave_hold = 1'b0;
    wd_enable = 1'b1;
    repeat (4) tick();

    // Reset asserted during the first STOP phase.
    slave_base = scl_rises;
    slave_n = 1;
    slave_hold = 1'b1;
    n = 0;
    while (sda_oe !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("reach_st_a", 32'(scl_oe & sda_oe), 1);
    check("cnt_before_rst", 32'(recov_cnt), exp_cnt);
    #2 sys_rst_n = 1'b0;
    #1;
    check("arst_scl_oe", 32'(scl_oe), 0);
    check("arst_sda_oe", 32'(sda_oe), 0);
    check("arst_stuck", 32'(stuck_flag), 0);
    check("arst_recov_cnt", 32'(recov_cnt), 0);
    check("arst_busy", 32'(recov_busy), 0);
    exp_cnt = 0;
    slave_hold = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_idle_en", 32'(cnt_en), 0);
    check("post_rst_idle_busy", 32'(recov_busy), 0);
    scl_drv = 1'b0;
    wait_en(1'b1, 20, n);
    check("post_rst_mon_lat", n, 3);
    scl_drv = 1'b1;
    wait_en(1'b0, 20, n);
    check("post_rst_fall_lat", n, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
